// File: rtl/addr8u_share_arb.sv
// Two-requester round-robin arbiter in front of one shared 8-bit adder, one transaction in flight.
// Optional self-check (macro ADDR8U_SHARE_ARB_CHECK_EN) re-adds with swapped operands and flags a mismatch.
module addr8u_share_arb #(
    parameter int RR_INIT = 0
`ifdef ADDR8U_SHARE_ARB_CHECK_EN
    , parameter bit FAULT_INJECT = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [8:0] rsp_sum,
    output logic       rsp_id,
    output logic       rsp_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_RESP  = 2'd2
`ifdef ADDR8U_SHARE_ARB_CHECK_EN
        , S_CHECK = 2'd3
`endif
    } state_t;

    localparam logic PRIO_RST = (RR_INIT != 0);

    state_t     state_q, state_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic       id_q, id_d;
    logic [8:0] sum_q, sum_d;
    logic       prio_q, prio_d;
    logic       gnt_id;
    logic       is_idle;
    logic [7:0] add_x, add_y;
    logic [8:0] add_sum;
`ifdef ADDR8U_SHARE_ARB_CHECK_EN
    logic       err_q, err_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            id_q    <= 1'b0;
            sum_q   <= 9'h000;
            prio_q  <= PRIO_RST;
`ifdef ADDR8U_SHARE_ARB_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
            prio_q  <= prio_d;
`ifdef ADDR8U_SHARE_ARB_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        is_idle    = (state_q == S_IDLE);
        // Contention goes to the priority holder; otherwise the lone valid requester.
        gnt_id     = (req0_valid && req1_valid) ? prio_q : req1_valid;
        req0_ready = is_idle && req0_valid && !gnt_id;
        req1_ready = is_idle && req1_valid && gnt_id;

        add_x = a_q;
        add_y = b_q;
`ifdef ADDR8U_SHARE_ARB_CHECK_EN
        if (state_q == S_CHECK) begin
            add_x = b_q;
            add_y = a_q;
        end
`endif
        add_sum = {1'b0, add_x} + {1'b0, add_y};

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        sum_d   = sum_q;
        prio_d  = prio_q;
`ifdef ADDR8U_SHARE_ARB_CHECK_EN
        err_d   = err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (req0_ready || req1_ready) begin
                    a_d     = gnt_id ? req1_a : req0_a;
                    b_d     = gnt_id ? req1_b : req0_b;
                    id_d    = gnt_id;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
`ifdef ADDR8U_SHARE_ARB_CHECK_EN
                sum_d   = add_sum ^ (FAULT_INJECT ? 9'h008 : 9'h000);
                state_d = S_CHECK;
`else
                sum_d   = add_sum;
                state_d = S_RESP;
`endif
            end
`ifdef ADDR8U_SHARE_ARB_CHECK_EN
            S_CHECK: begin
                err_d   = (add_sum != sum_q);
                state_d = S_RESP;
            end
`endif
            S_RESP: begin
                if (rsp_ready) begin
                    prio_d  = !id_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_sum   = sum_q;
    assign rsp_id    = id_q;
    assign busy      = !is_idle;
`ifdef ADDR8U_SHARE_ARB_CHECK_EN
    assign rsp_err   = err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_addr8u_share_arb.sv
// Scoreboard bench for addr8u_share_arb: driver predicts grants and sums, monitor checks responses.
module tb_addr8u_share_arb;

`ifdef ADDR8U_SHARE_ARB_CHECK_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam int RR = 0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [8:0] rsp_sum;

    always #5 clk = ~clk;

    addr8u_share_arb #(.RR_INIT(RR)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
        .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
    );

`ifdef ADDR8U_SHARE_ARB_CHECK_EN
    logic       f_v0, f_r0, f_r1, f_rv, f_rr, f_id, f_err, f_busy;
    logic [8:0] f_sum;
    addr8u_share_arb #(.RR_INIT(RR), .FAULT_INJECT(1'b1)) dut_f (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(f_v0), .req0_ready(f_r0), .req0_a(8'h12), .req0_b(8'h34),
        .req1_valid(1'b0), .req1_ready(f_r1), .req1_a(8'h00), .req1_b(8'h00),
        .rsp_valid(f_rv), .rsp_ready(f_rr), .rsp_sum(f_sum),
        .rsp_id(f_id), .rsp_err(f_err), .busy(f_busy)
    );
`endif

    typedef struct {
        logic       id;
        logic [8:0] sum;
        int         acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic m_busy = 1'b0;
    logic m_prio = RR[0];
    bit   seen_valid = 0;
    bit   holding = 0;
    logic [8:0] hold_sum;
    logic       hold_id;
    bit   last_acc;
    logic last_id;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One bus cycle: drive at the falling edge, check readies against the model before the rising edge.
    task automatic cycle(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                         input logic v1, input logic [7:0] a1, input logic [7:0] b1,
                         input logic rr);
        logic g;
        logic any;
        exp_t e;
        @(negedge clk);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        rsp_ready  = rr;
        #3;
        any = v0 | v1;
        g   = (v0 && v1) ? m_prio : v1;
        chk("busy", busy, m_busy);
        chk("ready0", req0_ready, !m_busy && any && !g);
        chk("ready1", req1_ready, !m_busy && any && g);
        last_acc = 0;
        if (!m_busy && any) begin
            e.id  = g;
            e.sum = g ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
            e.acc = cyc;
            q.push_back(e);
            m_busy   = 1'b1;
            last_acc = 1;
            last_id  = g;
        end
    endtask

    task automatic send(input logic id, input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        do begin
            if (id) cycle(1'b0, 8'h00, 8'h00, 1'b1, a, b, 1'b1);
            else    cycle(1'b1, a, b, 1'b0, 8'h00, 8'h00, 1'b1);
            n++;
        end while (!last_acc && n < 40);
        chk("send_accepted", last_acc, 1);
    endtask

    task automatic idle_until_done();
        int n;
        n = 0;
        while ((q.size() != 0 || m_busy) && n < 60) begin
            cycle(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
            n++;
        end
        chk("drain_queue", q.size(), 0);
    endtask

    // Monitor: samples just before each rising edge, pops the scoreboard on each response handshake.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) continue;
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_rsp", rsp_valid, 0);
                end else begin
                    if (!seen_valid) begin
                        chk("latency", cyc - q[0].acc, LAT);
                        seen_valid = 1;
                    end
                    if (holding) begin
                        chk("hold_sum", rsp_sum, hold_sum);
                        chk("hold_id", rsp_id, hold_id);
                    end
                    if (rsp_ready) begin
                        chk("rsp_sum", rsp_sum, q[0].sum);
                        chk("rsp_id", rsp_id, q[0].id);
                        chk("rsp_err", rsp_err, 0);
                        $display("RSP id=%0d sum=%03h err=%0d cycle=%0d", rsp_id, rsp_sum, rsp_err, cyc);
                        m_prio = !q[0].id;
                        m_busy = 1'b0;
                        void'(q.pop_front());
                        seen_valid = 0;
                        holding    = 0;
                    end else begin
                        holding  = 1;
                        hold_sum = rsp_sum;
                        hold_id  = rsp_id;
                    end
                end
            end
        end
    end

    initial begin
        logic exp_ids [4];
        int k;
        int n;
        exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        rsp_ready = 1'b1;
`ifdef ADDR8U_SHARE_ARB_CHECK_EN
        f_v0 = 1'b0; f_rr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_sum", rsp_sum, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Contention straight after reset: grants must alternate starting at RR_INIT.
        k = 0; n = 0;
        while (k < 4 && n < 60) begin
            cycle(1'b1, 8'($urandom), 8'($urandom), 1'b1, 8'($urandom), 8'($urandom), 1'b1);
            if (last_acc) begin
                chk("contention_id", req1_ready, exp_ids[k]);
                k++;
            end
            n++;
        end
        chk("contention_count", k, 4);
        idle_until_done();

        send(1'b0, 8'h7F, 8'h01);
        idle_until_done();
        send(1'b1, 8'hFF, 8'hFF);
        idle_until_done();
        send(1'b0, 8'h00, 8'h00);
        idle_until_done();

        // Backpressure: both requesters keep asking while the response is stalled.
        send(1'b0, 8'hA5, 8'h5A);
        repeat (LAT + 5) cycle(1'b1, 8'h11, 8'h22, 1'b1, 8'h33, 8'h44, 1'b0);
        idle_until_done();

        // Reset while in EXEC with priority held by requester 1.
        chk("prio_before_rst", m_prio, 1);
        send(1'b0, 8'h10, 8'h20);
        #3;
        chk("busy_exec", busy, 1);
        req0_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_rsp_sum", rsp_sum, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rsp_id", rsp_id, 0);
        q.delete();
        m_busy = 1'b0;
        m_prio = RR[0];
        seen_valid = 0;
        holding = 0;
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 8'h01, 8'h02, 1'b1, 8'h03, 8'h04, 1'b1);
        chk("post_rst_grant0", req0_ready, 1);
        idle_until_done();

        // Randomised traffic with random valids (including drop-before-grant) and backpressure.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                  1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                  ($urandom_range(0, 9) < 7));
        end
        idle_until_done();

`ifdef ADDR8U_SHARE_ARB_CHECK_EN
        @(negedge clk);
        f_v0 = 1'b1;
        n = 0;
        while (!f_r0 && n < 10) begin @(negedge clk); n++; end
        @(negedge clk);
        f_v0 = 1'b0;
        n = 0;
        while (!f_rv && n < 10) begin @(negedge clk); n++; end
        chk("fault_rsp_valid", f_rv, 1);
        chk("fault_rsp_err", f_err, 1);
        f_rr = 1'b1;
        @(negedge clk);
        f_rr = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
